// File: rtl/memtest_stat_bcd_pkg.sv
// memtest_stat_bcd_pkg
//   Shared definitions for the memtest status BCD converter: default count
//   width and digit count, the converter FSM state type, the BCD digit type
//   and the per-digit add-3 correction used by each conversion lane.
package memtest_stat_bcd_pkg;

    localparam int MEMTEST_CNT_W      = 32;
    localparam int MEMTEST_BCD_DIGITS = 10;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    typedef logic [3:0] bcd_digit_t;

    // Double-dabble correction: a digit >= 5 would overflow past 9 on the next
    // shift, so pre-add 3. Stays within the digit (no carry out).
    function automatic bcd_digit_t bcd_add3(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/memtest_stat_bcd_bin2bcd_lane.sv
// bin2bcd_lane
//   One shift-and-add-3 conversion datapath. 'load' captures a binary operand
//   and clears the BCD accumulator; each 'step' applies the add-3 correction
//   to every digit and shifts {bcd, bin} left by one. After WIDTH steps 'bcd'
//   holds the packed BCD of the loaded operand (digit 0 in bits [3:0]).
//   Ports: clk, rst_n (async active-low), load, step, load_val[WIDTH], bcd[4*DIGITS].
module bin2bcd_lane
    import memtest_stat_bcd_pkg::*;
#(
    parameter int WIDTH  = MEMTEST_CNT_W,
    parameter int DIGITS = MEMTEST_BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [WIDTH-1:0]      load_val,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [WIDTH-1:0]          bin_q, bin_d;
    logic [4*DIGITS-1:0]       bcd_q, bcd_d;
    logic [4*DIGITS-1:0]       bcd_adj;
    logic [4*DIGITS+WIDTH-1:0] shifted;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = bcd_add3(bcd_q[4*i +: 4]);
        end
        shifted = {bcd_adj, bin_q} << 1;

        bin_d = bin_q;
        bcd_d = bcd_q;
        if (load) begin
            bin_d = load_val;
            bcd_d = '0;
        end else if (step) begin
            bin_d = shifted[WIDTH-1:0];
            bcd_d = shifted[WIDTH +: 4*DIGITS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/memtest_stat_bcd.sv
// memtest_stat_bcd
//   Converts the SDRAM tester's pass/fail counters to packed BCD for the
//   status overlay. A snapshot is taken whenever either count differs from
//   the last snapshot (unless frozen), converted over WIDTH cycles, and the
//   results are published together with a one-cycle 'update' pulse so the
//   display never sees a half-converted value.
//   Optional macro MEMTEST_FIRST_FAIL_EN adds a third lane that captures the
//   pass count at the first failure (ff_bcd/ff_valid); otherwise those ports
//   are tied to 0.
//   Ports: clk, rst_n (async active-low), passcount, failcount, freeze,
//          pass_bcd, fail_bcd, valid, update, busy, ff_bcd, ff_valid.
module memtest_stat_bcd
    import memtest_stat_bcd_pkg::*;
#(
    parameter int WIDTH  = MEMTEST_CNT_W,
    parameter int DIGITS = MEMTEST_BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      passcount,
    input  logic [WIDTH-1:0]      failcount,
    input  logic                  freeze,
    output logic [4*DIGITS-1:0]   pass_bcd,
    output logic [4*DIGITS-1:0]   fail_bcd,
    output logic                  valid,
    output logic                  update,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   ff_bcd,
    output logic                  ff_valid
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef MEMTEST_FIRST_FAIL_EN
    localparam int LANES = 3;
`else
    localparam int LANES = 2;
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     snap_pass_q, snap_pass_d;
    logic [WIDTH-1:0]     snap_fail_q, snap_fail_d;
    logic [4*DIGITS-1:0]  pass_bcd_q, pass_bcd_d;
    logic [4*DIGITS-1:0]  fail_bcd_q, fail_bcd_d;
    logic                 valid_q, valid_d;
    logic                 update_q, update_d;
    logic                 busy_q, busy_d;
    logic                 load, step;

    logic [LANES-1:0]                  lane_load;
    logic [LANES-1:0][WIDTH-1:0]       lane_val;
    logic [LANES-1:0][4*DIGITS-1:0]    lane_bcd;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_pass_d = snap_pass_q;
        snap_fail_d = snap_fail_q;
        pass_bcd_d  = pass_bcd_q;
        fail_bcd_d  = fail_bcd_q;
        valid_d     = valid_q;
        update_d    = 1'b0;
        busy_d      = busy_q;
        load        = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                // Comparing against the snapshot (not the previous input)
                // means changes ignored during CONV/DONE are picked up here.
                if (!freeze && (passcount != snap_pass_q || failcount != snap_fail_q)) begin
                    snap_pass_d = passcount;
                    snap_fail_d = failcount;
                    load        = 1'b1;
                    cnt_d       = CW'(WIDTH);
                    busy_d      = 1'b1;
                    state_d     = CONV;
                end
            end
            CONV: begin
                step  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                pass_bcd_d = lane_bcd[0];
                fail_bcd_d = lane_bcd[1];
                valid_d    = 1'b1;
                update_d   = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            snap_pass_q <= '0;
            snap_fail_q <= '0;
            pass_bcd_q  <= '0;
            fail_bcd_q  <= '0;
            valid_q     <= 1'b0;
            update_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_pass_q <= snap_pass_d;
            snap_fail_q <= snap_fail_d;
            pass_bcd_q  <= pass_bcd_d;
            fail_bcd_q  <= fail_bcd_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bin2bcd_lane #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (lane_load[l]),
            .step     (step),
            .load_val (lane_val[l]),
            .bcd      (lane_bcd[l])
        );
    end

`ifdef MEMTEST_FIRST_FAIL_EN
    logic                 ff_arm;
    logic                 ff_pend_q, ff_pend_d;
    logic                 ff_clr_q, ff_clr_d;
    logic                 ff_valid_q, ff_valid_d;
    logic [4*DIGITS-1:0]  ff_bcd_q, ff_bcd_d;

    // First failure: previous snapshot had no fails, the new one has some.
    assign ff_arm = (snap_fail_q == '0) && (failcount != '0);

    always_comb begin
        lane_val  = {passcount, failcount, passcount};
        lane_load = {load & ff_arm, load, load};
    end

    always_comb begin
        ff_pend_d  = ff_pend_q;
        ff_clr_d   = ff_clr_q;
        ff_valid_d = ff_valid_q;
        ff_bcd_d   = ff_bcd_q;
        if (load) begin
            ff_pend_d = ff_arm;
            ff_clr_d  = (failcount == '0);
        end
        if (state_q == DONE) begin
            if (ff_pend_q) begin
                ff_bcd_d   = lane_bcd[2];
                ff_valid_d = 1'b1;
            end else if (ff_clr_q) begin
                ff_bcd_d   = '0;
                ff_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_pend_q  <= 1'b0;
            ff_clr_q   <= 1'b0;
            ff_valid_q <= 1'b0;
            ff_bcd_q   <= '0;
        end else begin
            ff_pend_q  <= ff_pend_d;
            ff_clr_q   <= ff_clr_d;
            ff_valid_q <= ff_valid_d;
            ff_bcd_q   <= ff_bcd_d;
        end
    end

    assign ff_bcd   = ff_bcd_q;
    assign ff_valid = ff_valid_q;
`else
    always_comb begin
        lane_val  = {failcount, passcount};
        lane_load = {load, load};
    end

    assign ff_bcd   = '0;
    assign ff_valid = 1'b0;
`endif

    assign pass_bcd = pass_bcd_q;
    assign fail_bcd = fail_bcd_q;
    assign valid    = valid_q;
    assign update   = update_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_memtest_stat_bcd.sv
// tb_memtest_stat_bcd
//   Self-checking bench: a timer-based reference model (decimal digits by
//   repeated /10) is compared against every DUT output on each falling edge,
//   plus directed checks on latency, constants and pulse counts.
module tb_memtest_stat_bcd;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;
    localparam int BW     = 4*DIGITS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] passcount, failcount;
    logic             freeze;
    logic [BW-1:0]    pass_bcd, fail_bcd, ff_bcd;
    logic             valid, update, busy, ff_valid;

    int n_chk  = 0;
    int n_fail = 0;

    memtest_stat_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .passcount (passcount),
        .failcount (failcount),
        .freeze    (freeze),
        .pass_bcd  (pass_bcd),
        .fail_bcd  (fail_bcd),
        .valid     (valid),
        .update    (update),
        .busy      (busy),
        .ff_bcd    (ff_bcd),
        .ff_valid  (ff_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] to_bcd(input longint unsigned v);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // ---------------- reference model ----------------
    int               m_timer;
    logic [WIDTH-1:0] m_sp, m_sf;
    logic [BW-1:0]    m_pass, m_fail, m_ff, m_ff_cap;
    logic             m_valid, m_upd, m_busy, m_ffv, m_ff_pend, m_ff_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_timer <= 0; m_sp <= '0; m_sf <= '0;
            m_pass <= '0; m_fail <= '0; m_valid <= 0; m_upd <= 0; m_busy <= 0;
            m_ff <= '0; m_ffv <= 0; m_ff_pend <= 0; m_ff_clr <= 0; m_ff_cap <= '0;
        end else if (m_timer == 0) begin
            m_upd <= 0;
            if (!freeze && (passcount != m_sp || failcount != m_sf)) begin
                m_sp <= passcount; m_sf <= failcount;
                m_timer <= WIDTH + 1; m_busy <= 1;
                m_ff_pend <= (m_sf == 0) && (failcount != 0);
                m_ff_clr  <= (failcount == 0);
                m_ff_cap  <= to_bcd(passcount);
            end
        end else begin
            m_timer <= m_timer - 1;
            if (m_timer == 1) begin
                m_pass <= to_bcd(m_sp); m_fail <= to_bcd(m_sf);
                m_valid <= 1; m_upd <= 1; m_busy <= 0;
`ifdef MEMTEST_FIRST_FAIL_EN
                if (m_ff_pend) begin m_ff <= m_ff_cap; m_ffv <= 1; end
                else if (m_ff_clr) begin m_ff <= '0; m_ffv <= 0; end
`endif
            end
        end
    end

    // ---------------- monitor ----------------
    int            upd_cnt = 0;
    logic [BW-1:0] upd_q[$];

    always @(negedge clk) begin
        chk("pass_bcd", 64'(pass_bcd), 64'(m_pass));
        chk("fail_bcd", 64'(fail_bcd), 64'(m_fail));
        chk("valid",    64'(valid),    64'(m_valid));
        chk("update",   64'(update),   64'(m_upd));
        chk("busy",     64'(busy),     64'(m_busy));
        chk("ff_bcd",   64'(ff_bcd),   64'(m_ff));
        chk("ff_valid", 64'(ff_valid), 64'(m_ffv));
        if (update) begin
            upd_cnt++;
            upd_q.push_back(pass_bcd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic settle();
        int k;
        for (k = 0; k < 300; k++) begin
            tick();
            if (m_timer == 0 && (freeze || (passcount == m_sp && failcount == m_sf))) break;
        end
        if (k == 300) chk("settle_timeout", 1, 0);
        tick(2);
    endtask

    initial begin
        int base, lat;
        rst_n = 1'b0; passcount = '0; failcount = '0; freeze = 1'b0;
        tick(3);
        chk("rst_pass", 64'(pass_bcd), 0);
        chk("rst_valid", 64'(valid), 0);
        rst_n = 1'b1;
        tick(5);
        chk("zero_no_conv", 64'(valid), 0);

        // basic conversion and latency
        passcount = 32'd1234; failcount = '0;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (update) begin lat = n; break; end
        end
        chk("latency", 64'(lat), 64'(WIDTH + 2));
        #1;
        chk("bcd_1234", 64'(pass_bcd), 64'h1234);
        chk("fail_zero", 64'(fail_bcd), 0);
        chk("valid_1", 64'(valid), 1);
        settle();

        // all ones, both counters at once
        base = upd_cnt;
        passcount = 32'hFFFF_FFFF; failcount = 32'hFFFF_FFFF;
        settle();
        chk("max_pass", 64'(pass_bcd), 64'h42_9496_7295);
        chk("max_fail", 64'(fail_bcd), 64'h42_9496_7295);
        chk("max_pulses", 64'(upd_cnt - base), 1);

        // changes during CONV
        base = upd_cnt; upd_q.delete();
        passcount = 32'd5; failcount = 32'd0;
        tick(2); passcount = 32'd6;
        tick();  passcount = 32'd7;
        settle();
        chk("burst_pulses", 64'(upd_cnt - base), 2);
        if (upd_q.size() >= 2) begin
            chk("burst_first", 64'(upd_q[0]), 64'h5);
            chk("burst_last",  64'(upd_q[1]), 64'h7);
        end else chk("burst_q", 64'(upd_q.size()), 2);

        // freeze
        base = upd_cnt;
        freeze = 1'b1; passcount = 32'd99;
        tick(50);
        chk("freeze_busy", 64'(busy), 0);
        chk("freeze_pulses", 64'(upd_cnt - base), 0);
        freeze = 1'b0;
        settle();
        chk("unfreeze_99", 64'(pass_bcd), 64'h99);

        // freeze asserted mid-conversion does not abort it
        base = upd_cnt;
        passcount = 32'd31415;
        tick(5); freeze = 1'b1;
        tick(40);
        chk("freeze_mid", 64'(pass_bcd), 64'h31415);
        chk("freeze_mid_pulses", 64'(upd_cnt - base), 1);
        freeze = 1'b0;

        // clear to zero converts to zero digits
        passcount = '0; failcount = '0;
        settle();
        chk("clear_zero", 64'(pass_bcd), 0);
        chk("clear_valid", 64'(valid), 1);

        // reset at CONV step 10
        passcount = 32'd777; failcount = 32'd3;
        tick(11);
        base = upd_cnt;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pass", 64'(pass_bcd), 0);
        chk("arst_valid", 64'(valid), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_update", 64'(update), 0);
        tick(3);
        chk("arst_pulses", 64'(upd_cnt - base), 0);
        rst_n = 1'b1;
        settle();
        chk("post_rst_pass", 64'(pass_bcd), 64'h777);
        chk("post_rst_fail", 64'(fail_bcd), 64'h3);

        // first-fail capture sequence
        passcount = 32'd57; failcount = '0;
        settle();
        failcount = 32'd1;
        settle();
`ifdef MEMTEST_FIRST_FAIL_EN
        chk("ff_57", 64'(ff_bcd), 64'h57);
        chk("ff_valid_1", 64'(ff_valid), 1);
`endif
        passcount = 32'd60; failcount = 32'd2;
        settle();
`ifdef MEMTEST_FIRST_FAIL_EN
        chk("ff_hold", 64'(ff_bcd), 64'h57);
`endif
        failcount = '0;
        settle();
`ifdef MEMTEST_FIRST_FAIL_EN
        chk("ff_clear", 64'(ff_valid), 0);
`endif

        // randomized phase
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: passcount = $urandom;
                1: failcount = $urandom_range(0, 20);
                2: begin passcount = $urandom_range(0, 999); failcount = $urandom; end
                default: begin passcount = '0; failcount = '0; end
            endcase
            freeze = ($urandom_range(0, 5) == 0);
            tick($urandom_range(1, 45));
        end
        freeze = 1'b0;
        settle();
        chk("rand_final_pass", 64'(pass_bcd), 64'(to_bcd(64'(passcount))));
        chk("rand_final_fail", 64'(fail_bcd), 64'(to_bcd(64'(failcount))));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
